mem_arbiter: RTL and testbench

Two-port arbiter for the single 8-bit external memory bus. It shares the bus between the CPU core (20-bit address, 8-bit data in/out, write enable) and a DMA/video fetch requester. Each access is sequenced as a fixed-length slot with a one-cycle completion pulse. It sits between the core/DMA and the SRAM/BRAM pins and is the only driver of the memory address, write-data and write-enable lines.

---
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: slot-based arbiter sharing the 8-bit external memory bus between CPU and DMA.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise DMA has priority with a burst limit.
module mem_arbiter #(
    parameter int WAIT      = 1,
    parameter int DMA_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [19:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_wren,
    output logic        cpu_ready,
    output logic [7:0]  cpu_data,
    input  logic        dma_req,
    input  logic [19:0] dma_address,
    input  logic [7:0]  dma_out,
    input  logic        dma_wren,
    output logic        dma_ack,
    output logic [7:0]  dma_data,
    output logic [19:0] mem_address,
    output logic [7:0]  mem_out,
    output logic        mem_wren,
    input  logic [7:0]  mem_data
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [2:0] WAITV = 3'(WAIT);

    state_t     state;
    logic [2:0] cnt;
    logic       owner;
    logic       wr;
    logic       pick_dma;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;

    // a tie goes to whichever port did not win the previous slot
    always_comb pick_dma = dma_req & (~cpu_req | ~last_owner);
`else
    localparam logic [3:0] BURSTV = 4'(DMA_BURST);

    logic [3:0] bcnt;

    // DMA wins unless it has used up its burst while the CPU waits
    always_comb pick_dma = dma_req & ~(cpu_req & (bcnt == BURSTV));
`endif

    // slot sequencer: grant in IDLE, hold the bus in ACC, pulse ready in DONE
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            owner       <= 1'b0;
            wr          <= 1'b0;
            cpu_ready   <= 1'b0;
            cpu_data    <= 8'd0;
            dma_ack     <= 1'b0;
            dma_data    <= 8'd0;
            mem_address <= 20'd0;
            mem_out     <= 8'd0;
            mem_wren    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner  <= 1'b1;
`else
            bcnt        <= 4'd0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req | dma_req) begin
                        owner       <= pick_dma;
                        mem_address <= pick_dma ? dma_address : cpu_address;
                        mem_out     <= pick_dma ? dma_out : cpu_out;
                        mem_wren    <= pick_dma ? dma_wren : cpu_wren;
                        wr          <= pick_dma ? dma_wren : cpu_wren;
                        cnt         <= 3'd0;
                        state       <= ACC;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner  <= pick_dma;
`else
                        bcnt <= (pick_dma & cpu_req) ? bcnt + 4'd1 : 4'd0;
`endif
                    end
                end
                ACC: begin
                    mem_wren <= 1'b0;
                    cnt      <= cnt + 3'd1;
                    if (cnt == WAITV) begin
                        state <= DONE;
                        if (owner) begin
                            dma_ack <= 1'b1;
                            if (!wr) dma_data <= mem_data;
                        end else begin
                            cpu_ready <= 1'b1;
                            if (!wr) cpu_data <= mem_data;
                        end
                    end
                end
                DONE: begin
                    cpu_ready <= 1'b0;
                    dma_ack   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of slot timing, arbitration order and reset abort.
// Two instances share inputs: u1 with WAIT=1, u3 with WAIT=3.
module tb_mem_arbiter;
    logic        clock = 0;
    logic        reset;
    logic        cpu_req, cpu_wren, dma_req, dma_wren;
    logic [19:0] cpu_address, dma_address;
    logic [7:0]  cpu_out, dma_out, mem_data;

    logic        cpu_ready, dma_ack, mem_wren;
    logic [7:0]  cpu_data, dma_data, mem_out;
    logic [19:0] mem_address;

    logic        w3_ready, w3_ack, w3_wren;
    logic [7:0]  w3_cdata, w3_ddata, w3_mout;
    logic [19:0] w3_maddr;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.WAIT(1), .DMA_BURST(4)) u1 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_address(cpu_address),
        .cpu_out(cpu_out), .cpu_wren(cpu_wren),
        .cpu_ready(cpu_ready), .cpu_data(cpu_data),
        .dma_req(dma_req), .dma_address(dma_address),
        .dma_out(dma_out), .dma_wren(dma_wren),
        .dma_ack(dma_ack), .dma_data(dma_data),
        .mem_address(mem_address), .mem_out(mem_out),
        .mem_wren(mem_wren), .mem_data(mem_data)
    );

    mem_arbiter #(.WAIT(3), .DMA_BURST(4)) u3 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_address(cpu_address),
        .cpu_out(cpu_out), .cpu_wren(cpu_wren),
        .cpu_ready(w3_ready), .cpu_data(w3_cdata),
        .dma_req(dma_req), .dma_address(dma_address),
        .dma_out(dma_out), .dma_wren(dma_wren),
        .dma_ack(w3_ack), .dma_data(w3_ddata),
        .mem_address(w3_maddr), .mem_out(w3_mout),
        .mem_wren(w3_wren), .mem_data(mem_data)
    );

    typedef struct {
        logic        creq;
        logic [19:0] caddr;
        logic [7:0]  cout;
        logic        cwr;
        logic        dreq;
        logic [19:0] daddr;
        logic [7:0]  dout;
        logic        dwr;
        logic [7:0]  md;
        logic        e_rdy;
        logic [7:0]  e_cdata;
        logic        e_ack;
        logic [7:0]  e_ddata;
        logic [19:0] e_maddr;
        logic [7:0]  e_mout;
        logic        e_mwr;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1;
        cpu_req     = 0; cpu_wren = 0; cpu_address = 0; cpu_out = 0;
        dma_req     = 0; dma_wren = 0; dma_address = 0; dma_out = 0;
        mem_data    = 0;
        repeat (2) tick();
        reset = 0;
    endtask

    initial begin
        bit exp_dma [10];
        int gap;
        bit got;

        // cycle-by-cycle: CPU read then DMA write, WAIT=1
        tbl[0]  = '{1, 20'h12345, 8'h00, 0, 0, 20'h00000, 8'h00, 0, 8'h00,
                    0, 8'h00, 0, 8'h00, 20'h00000, 8'h00, 0};
        tbl[1]  = '{1, 20'h12345, 8'h00, 0, 0, 20'h00000, 8'h00, 0, 8'h00,
                    0, 8'h00, 0, 8'h00, 20'h12345, 8'h00, 0};
        tbl[2]  = '{1, 20'h12345, 8'h00, 0, 0, 20'h00000, 8'h00, 0, 8'hA5,
                    0, 8'h00, 0, 8'h00, 20'h12345, 8'h00, 0};
        tbl[3]  = '{1, 20'h12345, 8'h00, 0, 0, 20'h00000, 8'h00, 0, 8'h00,
                    1, 8'hA5, 0, 8'h00, 20'h12345, 8'h00, 0};
        tbl[4]  = '{0, 20'h12345, 8'h00, 0, 0, 20'h00000, 8'h00, 0, 8'h00,
                    0, 8'hA5, 0, 8'h00, 20'h12345, 8'h00, 0};
        tbl[5]  = '{0, 20'h00000, 8'h00, 0, 0, 20'h00000, 8'h00, 0, 8'h00,
                    0, 8'hA5, 0, 8'h00, 20'h12345, 8'h00, 0};
        tbl[6]  = '{0, 20'h00000, 8'h00, 0, 1, 20'hB8000, 8'h41, 1, 8'h00,
                    0, 8'hA5, 0, 8'h00, 20'h12345, 8'h00, 0};
        tbl[7]  = '{0, 20'h00000, 8'h00, 0, 1, 20'hB8000, 8'h41, 1, 8'h00,
                    0, 8'hA5, 0, 8'h00, 20'hB8000, 8'h41, 1};
        tbl[8]  = '{0, 20'h00000, 8'h00, 0, 1, 20'hB8000, 8'h41, 1, 8'h5A,
                    0, 8'hA5, 0, 8'h00, 20'hB8000, 8'h41, 0};
        tbl[9]  = '{0, 20'h00000, 8'h00, 0, 1, 20'hB8000, 8'h41, 1, 8'h00,
                    0, 8'hA5, 1, 8'h00, 20'hB8000, 8'h41, 0};
        tbl[10] = '{0, 20'h00000, 8'h00, 0, 0, 20'h00000, 8'h00, 0, 8'h00,
                    0, 8'hA5, 0, 8'h00, 20'hB8000, 8'h41, 0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("v%0d cpu_ready", i), 32'(cpu_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d cpu_data", i), 32'(cpu_data), 32'(tbl[i].e_cdata));
            chk($sformatf("v%0d dma_ack", i), 32'(dma_ack), 32'(tbl[i].e_ack));
            chk($sformatf("v%0d dma_data", i), 32'(dma_data), 32'(tbl[i].e_ddata));
            chk($sformatf("v%0d mem_address", i), 32'(mem_address), 32'(tbl[i].e_maddr));
            chk($sformatf("v%0d mem_out", i), 32'(mem_out), 32'(tbl[i].e_mout));
            chk($sformatf("v%0d mem_wren", i), 32'(mem_wren), 32'(tbl[i].e_mwr));
            cpu_req     = tbl[i].creq;
            cpu_address = tbl[i].caddr;
            cpu_out     = tbl[i].cout;
            cpu_wren    = tbl[i].cwr;
            dma_req     = tbl[i].dreq;
            dma_address = tbl[i].daddr;
            dma_out     = tbl[i].dout;
            dma_wren    = tbl[i].dwr;
            mem_data    = tbl[i].md;
            tick();
        end

        // both ports requesting continuously
`ifdef ARB_ROUND_ROBIN_EN
        exp_dma = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_dma = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
        do_reset();
        cpu_address = 20'h11111;
        dma_address = 20'h22222;
        cpu_req = 1;
        dma_req = 1;
        for (int k = 0; k < 10; k++) begin
            gap = 0;
            got = 0;
            while (!got && gap < 8) begin
                tick();
                gap++;
                got = cpu_ready | dma_ack;
            end
            chk($sformatf("grant%0d pulse", k), 32'(got), 32'd1);
            chk($sformatf("grant%0d gap", k), 32'(gap), (k == 0) ? 32'd3 : 32'd4);
            chk($sformatf("grant%0d owner", k), 32'(dma_ack), 32'(exp_dma[k]));
            chk($sformatf("grant%0d one", k), 32'(cpu_ready & dma_ack), 32'd0);
            chk($sformatf("grant%0d addr", k), 32'(mem_address),
                exp_dma[k] ? 32'h22222 : 32'h11111);
        end

        // reset in cycle 1 of a DMA write aborts the slot
        do_reset();
        dma_req = 1; dma_address = 20'hB8000; dma_out = 8'h41; dma_wren = 1;
        tick();
        chk("abort wren c1", 32'(mem_wren), 32'd1);
        reset = 1;
        tick();
        chk("abort mem_wren", 32'(mem_wren), 32'd0);
        chk("abort mem_address", 32'(mem_address), 32'd0);
        chk("abort mem_out", 32'(mem_out), 32'd0);
        chk("abort dma_ack", 32'(dma_ack), 32'd0);
        chk("abort cpu_data", 32'(cpu_data), 32'd0);
        reset = 0;
        dma_req = 0; dma_wren = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("abort noack%0d", c), 32'(dma_ack), 32'd0);
        end
        cpu_req = 1; cpu_address = 20'h0ABCD; cpu_wren = 0; mem_data = 8'h3C;
        gap = 0;
        got = 0;
        while (!got && gap < 8) begin
            tick();
            gap++;
            got = cpu_ready;
        end
        cpu_req = 0;
        chk("after abort ready", 32'(got), 32'd1);
        chk("after abort latency", 32'(gap), 32'd3);
        chk("after abort data", 32'(cpu_data), 32'h3C);
        chk("after abort dma_ack", 32'(dma_ack), 32'd0);

        // WAIT=3 CPU read on u3
        do_reset();
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("w3 c%0d ready", c), 32'(w3_ready), 32'(c == 5));
            if (c == 5) chk("w3 data", 32'(w3_cdata), 32'hC3);
            if (c == 6) chk("w3 addr c6", 32'(w3_maddr), 32'h0A0A0);
            if (c == 7) chk("w3 addr c7", 32'(w3_maddr), 32'h54321);
            cpu_req     = 1;
            cpu_wren    = 0;
            cpu_address = (c >= 6) ? 20'h54321 : 20'h0A0A0;
            mem_data    = (c == 4) ? 8'hC3 : 8'h00;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
